gp_sbus_regbank: RTL and testbench
==================================

// Module: gp_sbus_regbank
// PURPOSE
//   Downstream target of the gp_engine AHB slave. Consumes its simple request bus
//   (valid/rd0_wr1/addr/wr_data) and returns ready/rd_valid/rd_data from a
//   flop-based register bank of DEPTH 32-bit words.
//   Adds programmable read latency and write busy cycles, so the AHB slave's
//   wait-state path is exercised.
//   Flags illegal accesses with a sticky error output.
// PARAMETERS
//   DATA_WIDTH  32            data width (bits)
//   ADDR_WIDTH  32            byte address width
//   DEPTH       16            number of words, 2..64
//   BASE_ADDR   32'h0000_0000 byte address of word 0, 4-byte aligned
//   RD_LAT      2             cycles from read accept to o_rd_valid, 1..15
//   WR_WS       1             busy cycles after a write accept, 0..15
//   ERR_DATA    32'hDEAD_BEEF read data returned for illegal reads
// PORTS
//   i_clk_ahb   in   1           clock
//   i_rst_ahb   in   1           synchronous reset, active-high
//   i_valid     in   1           request valid
//   i_rd0_wr1   in   1           0 = read, 1 = write
//   i_addr      in   ADDR_WIDTH  byte address
//   i_wr_data   in   DATA_WIDTH  write data, sampled on accept
//   i_err_clr   in   1           clears o_err; a new error in the same cycle wins
//   o_ready     out  1           can accept; also qualifies o_rd_valid
//   o_rd_valid  out  1           one-cycle read-data strobe
//   o_rd_data   out  DATA_WIDTH  read data; 0 when o_rd_valid is low
//   o_err       out  1           sticky: misaligned or out-of-range access seen
// BEHAVIOUR
//   Clock and reset: single clock. Reset is synchronous and active-high; it is
//   sampled on the i_clk_ahb edge.
//   Reset values: state=IDLE, all bank words=0, o_ready=1, o_rd_valid=0,
//   o_rd_data=0, o_err=0, all counters=0.
//   Reset mid-operation: any in-flight read or busy count is dropped; no
//   o_rd_valid is issued afterwards.
//   Accept: a request is accepted when i_valid && o_ready at the clock edge.
//   Only one request is outstanding at a time.
//   Legal access: addr[1:0]==0 and BASE_ADDR <= addr < BASE_ADDR + 4*DEPTH.
//   Word index = (addr - BASE_ADDR) >> 2.
//   Illegal access:
//     - write: bank unchanged.
//     - read: returns ERR_DATA with normal timing.
//     - both: o_err is set on the edge after the accept.
//   FSM states:
//     IDLE    o_ready=1. Read accept: to RD_WAIT (cnt=RD_LAT-1), or straight to
//             RD_RESP when RD_LAT==1. Write accept: bank word written at the
//             accept edge; to WR_BUSY (cnt=WR_WS) if WR_WS>0, else stay in IDLE.
//     RD_WAIT o_ready=0. cnt decrements; moves to RD_RESP when cnt==1.
//     RD_RESP o_ready=1, o_rd_valid=1, o_rd_data=captured word. A new accept in
//             this cycle follows the IDLE rules (back-to-back); otherwise to IDLE.
//     WR_BUSY o_ready=0. cnt decrements; moves to IDLE when cnt==1.
//   Read data is sampled from the bank at the accept edge. A write accepted
//   later cannot alter data already in flight.
//   Read latency: accept at edge T gives o_rd_valid high in cycle T+RD_LAT.
//   Write followed by read of the same address returns the new data.
//   i_rd0_wr1, i_addr and i_wr_data are don't-care when i_valid is low.
//   Widths: index is clog2(DEPTH) bits. Compare the range on the full
//   ADDR_WIDTH; there is no wrap-around past BASE_ADDR + 4*DEPTH.
//   Counters never underflow.
// TESTING
//   Reset: drive i_rst_ahb for 2 cycles -> o_ready=1, o_rd_valid=0, o_err=0;
//   every word reads back 0.
//   Write then read: write 32'hA5A5_0001 to BASE+8, then read BASE+8 with
//   RD_LAT=2 -> o_rd_valid exactly 2 cycles after accept, data 32'hA5A5_0001,
//   o_ready low for 1 cycle.
//   Back-to-back: assert a read accept in the RD_RESP cycle -> second
//   o_rd_valid RD_LAT cycles later, with no idle bubble.
//   Write busy: WR_WS=3, write then immediately request -> o_ready low for
//   exactly 3 cycles; the held request is accepted on the 4th cycle.
//   Illegal access: read BASE+4*DEPTH, then write BASE+2 ->
//     - read returns 32'hDEAD_BEEF;
//     - bank unchanged;
//     - o_err=1 until i_err_clr;
//     - with clear and a new error in the same cycle, o_err stays 1.
//   Reset mid-read: assert i_rst_ahb while in RD_WAIT -> no o_rd_valid,
//   o_ready=1 on the next cycle, bank=0.

Source files
------------

// File: rtl/gp_sbus_regbank.sv
`default_nettype none
// gp_sbus_regbank: flop register bank behind the gp_engine simple request bus,
// with programmable read latency, write busy cycles and a sticky access-error flag.
module gp_sbus_regbank #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DEPTH      = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    RD_LAT     = 2,
  parameter int                    WR_WS      = 1,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA   = DATA_WIDTH'(32'hDEAD_BEEF)
) (
  input  logic                  i_clk_ahb,
  input  logic                  i_rst_ahb,
  input  logic                  i_valid,
  input  logic                  i_rd0_wr1,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_err_clr,
  output logic                  o_ready,
  output logic                  o_rd_valid,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int AW1   = ADDR_WIDTH + 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RD_WAIT = 2'd1;
  localparam logic [1:0] S_RD_RESP = 2'd2;
  localparam logic [1:0] S_WR_BUSY = 2'd3;

  localparam logic [3:0] RD_LOAD = 4'(RD_LAT - 1);
  localparam logic [3:0] WR_LOAD = 4'(WR_WS);

  // Range limits carry one extra bit so BASE_ADDR + 4*DEPTH cannot wrap.
  localparam logic [AW1-1:0] BASE_EXT  = AW1'(BASE_ADDR);
  localparam logic [AW1-1:0] LIMIT_EXT = BASE_EXT + AW1'(4 * DEPTH);

  logic [1:0]            state;
  logic [3:0]            cnt;
  logic [DATA_WIDTH-1:0] bank [DEPTH];
  logic [DATA_WIDTH-1:0] rd_buf;
  logic                  err;
  logic                  err_pend;

  logic                  ready;
  logic                  accept;
  logic                  legal;
  logic [AW1-1:0]        addr_ext;
  logic [IDX_W-1:0]      idx;

  assign ready    = (state == S_IDLE) || (state == S_RD_RESP);
  assign accept   = i_valid && ready;
  assign addr_ext = {1'b0, i_addr};
  assign legal    = (i_addr[1:0] == 2'b00) && (addr_ext >= BASE_EXT) && (addr_ext < LIMIT_EXT);
  assign idx      = IDX_W'((i_addr - BASE_ADDR) >> 2);

  assign o_ready    = ready;
  assign o_rd_valid = (state == S_RD_RESP);
  assign o_rd_data  = (state == S_RD_RESP) ? rd_buf : '0;
  assign o_err      = err;

  always_ff @(posedge i_clk_ahb) begin
    if (i_rst_ahb) begin
      state    <= S_IDLE;
      cnt      <= '0;
      rd_buf   <= '0;
      err      <= 1'b0;
      err_pend <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        bank[i] <= '0;
      end
    end else begin
      // The error flag rises one edge after the offending accept; a fresh
      // error beats a simultaneous clear.
      err_pend <= accept && !legal;
      if (err_pend) begin
        err <= 1'b1;
      end else if (i_err_clr) begin
        err <= 1'b0;
      end

      if (accept && !i_rd0_wr1) begin
        rd_buf <= legal ? bank[idx] : ERR_DATA;
        if (RD_LAT == 1) begin
          state <= S_RD_RESP;
          cnt   <= '0;
        end else begin
          state <= S_RD_WAIT;
          cnt   <= RD_LOAD;
        end
      end else if (accept) begin
        if (legal) begin
          bank[idx] <= i_wr_data;
        end
        if (WR_WS > 0) begin
          state <= S_WR_BUSY;
          cnt   <= WR_LOAD;
        end else begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      end else begin
        case (state)
          S_RD_WAIT: begin
            if (cnt <= 4'd1) begin
              state <= S_RD_RESP;
              cnt   <= '0;
            end else begin
              cnt <= cnt - 4'd1;
            end
          end
          S_WR_BUSY: begin
            if (cnt <= 4'd1) begin
              state <= S_IDLE;
              cnt   <= '0;
            end else begin
              cnt <= cnt - 4'd1;
            end
          end
          default: begin
            state <= S_IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gp_sbus_regbank.sv
`default_nettype none
// Directed self-checking bench for gp_sbus_regbank (BASE 0x1000, DEPTH 16, RD_LAT 2, WR_WS 3).
module tb_gp_sbus_regbank;

  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic        rd0_wr1;
  logic [31:0] addr;
  logic [31:0] wr_data;
  logic        err_clr;
  logic        ready;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  gp_sbus_regbank #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .DEPTH     (16),
    .BASE_ADDR (BASE),
    .RD_LAT    (2),
    .WR_WS     (3),
    .ERR_DATA  (32'hDEAD_BEEF)
  ) dut (
    .i_clk_ahb (clk),
    .i_rst_ahb (rst),
    .i_valid   (valid),
    .i_rd0_wr1 (rd0_wr1),
    .i_addr    (addr),
    .i_wr_data (wr_data),
    .i_err_clr (err_clr),
    .o_ready   (ready),
    .o_rd_valid(rd_valid),
    .o_rd_data (rd_data),
    .o_err     (err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Read with RD_LAT=2: one RD_WAIT cycle, then the RD_RESP strobe.
  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
    chk({tag, "_pre_ready"}, 32'(ready), 32'd1);
    valid = 1'b1; rd0_wr1 = 1'b0; addr = a;
    tick;
    valid = 1'b0;
    chk({tag, "_wait_ready"}, 32'(ready), 32'd0);
    chk({tag, "_wait_valid"}, 32'(rd_valid), 32'd0);
    tick;
    chk({tag, "_resp_valid"}, 32'(rd_valid), 32'd1);
    chk({tag, "_resp_data"}, rd_data, exp);
    chk({tag, "_resp_ready"}, 32'(ready), 32'd1);
    tick;
    chk({tag, "_idle_valid"}, 32'(rd_valid), 32'd0);
    chk({tag, "_idle_data"}, rd_data, 32'd0);
  endtask

  // Write with WR_WS=3: ready low for exactly three cycles after accept.
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input string tag);
    chk({tag, "_pre_ready"}, 32'(ready), 32'd1);
    valid = 1'b1; rd0_wr1 = 1'b1; addr = a; wr_data = d;
    tick;
    valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_busy%0d", tag, i), 32'(ready), 32'd0);
      tick;
    end
    chk({tag, "_done_ready"}, 32'(ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; rd0_wr1 = 1'b0; addr = '0; wr_data = '0; err_clr = 1'b0;
    tick;
    tick;
    rst = 1'b0;
    chk("reset_ready", 32'(ready), 32'd1);
    chk("reset_rd_valid", 32'(rd_valid), 32'd0);
    chk("reset_rd_data", rd_data, 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    for (int i = 0; i < 16; i++) begin
      rd(BASE + 32'(4 * i), 32'd0, $sformatf("reset_word%0d", i));
    end

    wr(BASE + 32'h8, 32'hA5A5_0001, "wr_w2");
    wr(BASE, 32'h1111_0000, "wr_w0");
    wr(BASE + 32'h3C, 32'h3C3C_3C3C, "wr_w15");
    rd(BASE + 32'h8, 32'hA5A5_0001, "rd_w2");
    rd(BASE + 32'h3C, 32'h3C3C_3C3C, "rd_w15");
    chk("legal_no_err", 32'(err), 32'd0);

    // Back-to-back reads: second accept lands in the RD_RESP cycle.
    valid = 1'b1; rd0_wr1 = 1'b0; addr = BASE;
    tick;
    valid = 1'b0;
    chk("b2b_a_wait", 32'(ready), 32'd0);
    tick;
    chk("b2b_a_valid", 32'(rd_valid), 32'd1);
    chk("b2b_a_data", rd_data, 32'h1111_0000);
    valid = 1'b1; addr = BASE + 32'h8;
    tick;
    valid = 1'b0;
    chk("b2b_b_wait_ready", 32'(ready), 32'd0);
    chk("b2b_b_wait_valid", 32'(rd_valid), 32'd0);
    tick;
    chk("b2b_b_valid", 32'(rd_valid), 32'd1);
    chk("b2b_b_data", rd_data, 32'hA5A5_0001);
    tick;

    // Write followed by a held read request.
    valid = 1'b1; rd0_wr1 = 1'b1; addr = BASE + 32'h10; wr_data = 32'h55AA_55AA;
    tick;
    rd0_wr1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("held_busy%0d", i), 32'(ready), 32'd0);
      tick;
    end
    chk("held_ready4", 32'(ready), 32'd1);
    tick;
    valid = 1'b0;
    chk("held_accepted", 32'(ready), 32'd0);
    tick;
    chk("held_valid", 32'(rd_valid), 32'd1);
    chk("held_data", rd_data, 32'h55AA_55AA);
    tick;

    // Illegal reads above and below the window.
    rd(BASE + 32'h40, 32'hDEAD_BEEF, "ill_rd_hi");
    chk("ill_rd_err", 32'(err), 32'd1);
    rd(BASE - 32'h4, 32'hDEAD_BEEF, "ill_rd_lo");
    tick;
    chk("err_sticky", 32'(err), 32'd1);
    err_clr = 1'b1;
    tick;
    err_clr = 1'b0;
    chk("err_cleared", 32'(err), 32'd0);

    // Misaligned write aliasing word 0; clear held across the new error.
    valid = 1'b1; rd0_wr1 = 1'b1; addr = BASE + 32'h2; wr_data = 32'hFFFF_FFFF;
    tick;
    valid = 1'b0;
    err_clr = 1'b1;
    tick;
    chk("clr_vs_new_err", 32'(err), 32'd1);
    tick;
    chk("clr_after_err", 32'(err), 32'd0);
    err_clr = 1'b0;
    tick;
    chk("ill_wr_busy_done", 32'(ready), 32'd1);
    rd(BASE, 32'h1111_0000, "bank_unch_w0");
    rd(BASE + 32'h8, 32'hA5A5_0001, "bank_unch_w2");
    rd(BASE + 32'h9, 32'hDEAD_BEEF, "ill_rd_misal");

    // Reset while a read sits in RD_WAIT.
    valid = 1'b1; rd0_wr1 = 1'b0; addr = BASE + 32'h8;
    tick;
    valid = 1'b0;
    chk("midrd_wait", 32'(ready), 32'd0);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("midrd_ready", 32'(ready), 32'd1);
    chk("midrd_valid0", 32'(rd_valid), 32'd0);
    chk("midrd_err", 32'(err), 32'd0);
    tick;
    chk("midrd_valid1", 32'(rd_valid), 32'd0);
    tick;
    chk("midrd_valid2", 32'(rd_valid), 32'd0);
    rd(BASE + 32'h8, 32'd0, "midrd_bank_w2");
    rd(BASE, 32'd0, "midrd_bank_w0");
    rd(BASE + 32'h10, 32'd0, "midrd_bank_w4");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
